regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 117 +++++++++++
 tb/tb_regfile_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_reader: two-port round-robin arbiter that reads one register-file  |
// | entry per grant and holds each port's result until the consumer takes it.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_reader #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              reqValidA,
  input  logic [IDX_W-1:0]  reqIndexA,
  output logic              reqReadyA,
  input  logic              reqValidB,
  input  logic [IDX_W-1:0]  reqIndexB,
  output logic              reqReadyB,
  output logic              rspValidA,
  output logic [DATA_W-1:0] rspDataA,
  input  logic              rspReadyA,
  output logic              rspValidB,
  output logic [DATA_W-1:0] rspDataB,
  input  logic              rspReadyB,
  output logic [IDX_W-1:0]  readIndex,
  input  logic [DATA_W-1:0] readValue,
  output logic              busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  localparam logic c_PORT_A = 1'b0;
  localparam logic c_PORT_B = 1'b1;

  state_t             r_state;
  logic               r_owner;
  logic               r_lastServed;
  logic [IDX_W-1:0]   r_readIndex;
  logic               r_rspValidA;
  logic               r_rspValidB;
  logic [DATA_W-1:0]  r_rspDataA;
  logic [DATA_W-1:0]  r_rspDataB;

  logic               w_eligA;
  logic               w_eligB;
  logic               w_grantA;
  logic               w_grantB;

  // A port holding an undrained response is never eligible, so drain and
  // re-accept of the same port cannot coincide; readies stay low in reset.
  assign w_eligA  = clear_n && (r_state == S_IDLE) && reqValidA && !r_rspValidA;
  assign w_eligB  = clear_n && (r_state == S_IDLE) && reqValidB && !r_rspValidB;
  assign w_grantA = w_eligA && (!w_eligB || (r_lastServed == c_PORT_B));
  assign w_grantB = w_eligB && (!w_eligA || (r_lastServed == c_PORT_A));

  assign reqReadyA = w_grantA;
  assign reqReadyB = w_grantB;
  assign rspValidA = r_rspValidA;
  assign rspValidB = r_rspValidB;
  assign rspDataA  = r_rspDataA;
  assign rspDataB  = r_rspDataB;
  assign readIndex = r_readIndex;
  assign busy      = (r_state == S_READ);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state      <= S_IDLE;
      r_owner      <= c_PORT_A;
      r_lastServed <= c_PORT_B;
      r_readIndex  <= '0;
      r_rspValidA  <= 1'b0;
      r_rspValidB  <= 1'b0;
      r_rspDataA   <= '0;
      r_rspDataB   <= '0;
    end else begin
      if (r_rspValidA && rspReadyA) begin
        r_rspValidA <= 1'b0;
      end
      if (r_rspValidB && rspReadyB) begin
        r_rspValidB <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grantA) begin
            r_readIndex  <= reqIndexA;
            r_owner      <= c_PORT_A;
            r_lastServed <= c_PORT_A;
            r_state      <= S_READ;
          end else if (w_grantB) begin
            r_readIndex  <= reqIndexB;
            r_owner      <= c_PORT_B;
            r_lastServed <= c_PORT_B;
            r_state      <= S_READ;
          end
        end
        S_READ: begin
          // readValue is combinational on r_readIndex, valid one cycle after accept.
          if (r_owner == c_PORT_A) begin
            r_rspDataA  <= readValue;
            r_rspValidA <= 1'b1;
          end else begin
            r_rspDataB  <= readValue;
            r_rspValidB <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_reader.sv
`default_nettype none
// Testbench for regfile_reader: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_regfile_reader;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;

  logic              clock = 1'b0;
  logic              clear_n;
  logic              reqValidA, reqValidB;
  logic [IDX_W-1:0]  reqIndexA, reqIndexB;
  logic              reqReadyA, reqReadyB;
  logic              rspValidA, rspValidB;
  logic [DATA_W-1:0] rspDataA, rspDataB;
  logic              rspReadyA, rspReadyB;
  logic [IDX_W-1:0]  readIndex;
  logic [DATA_W-1:0] readValue;
  logic              busy;

  logic [DATA_W-1:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign readValue = rf[readIndex];

  regfile_reader #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock(clock), .clear_n(clear_n),
    .reqValidA(reqValidA), .reqIndexA(reqIndexA), .reqReadyA(reqReadyA),
    .reqValidB(reqValidB), .reqIndexB(reqIndexB), .reqReadyB(reqReadyB),
    .rspValidA(rspValidA), .rspDataA(rspDataA), .rspReadyA(rspReadyA),
    .rspValidB(rspValidB), .rspDataB(rspDataB), .rspReadyB(rspReadyB),
    .readIndex(readIndex), .readValue(readValue), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a pending read (port, index), a one-entry
  // response slot per port, and the last port served.
  bit                m_init = 0;
  bit                m_reading;
  int                m_owner;
  int                m_last;
  logic [IDX_W-1:0]  m_idx;
  bit                m_rv [2];
  logic [DATA_W-1:0] m_rd [2];

  function automatic bit m_elig(int p);
    bit v;
    v = (p == 0) ? reqValidA : reqValidB;
    return clear_n && !m_reading && v && !m_rv[p];
  endfunction

  function automatic bit m_grant(int p);
    bit mine, other;
    mine  = m_elig(p);
    other = m_elig(1 - p);
    return mine && (!other || m_last != p);
  endfunction

  always @(posedge clock) begin
    bit ga, gb;
    if (!clear_n) begin
      m_init = 1; m_reading = 0; m_owner = 0; m_last = 1; m_idx = '0;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    end else if (m_init) begin
      ga = m_grant(0);
      gb = m_grant(1);
      if (m_rv[0] && rspReadyA) m_rv[0] = 0;
      if (m_rv[1] && rspReadyB) m_rv[1] = 0;
      if (m_reading) begin
        m_rv[m_owner] = 1;
        m_rd[m_owner] = rf[m_idx];
        m_reading = 0;
      end else if (ga) begin
        m_idx = reqIndexA; m_owner = 0; m_last = 0; m_reading = 1;
      end else if (gb) begin
        m_idx = reqIndexB; m_owner = 1; m_last = 1; m_reading = 1;
      end
    end
  end

  // Single compare process; inputs change only just after posedge.
  always @(negedge clock) begin
    if (m_init) begin
      chk("cmp_reqReadyA", reqReadyA, m_grant(0));
      chk("cmp_reqReadyB", reqReadyB, m_grant(1));
      chk("cmp_busy",      busy,      m_reading);
      chk("cmp_rspValidA", rspValidA, m_rv[0]);
      chk("cmp_rspValidB", rspValidB, m_rv[1]);
      chk("cmp_rspDataA",  rspDataA,  m_rd[0]);
      chk("cmp_rspDataB",  rspDataB,  m_rd[1]);
      chk("cmp_readIndex", readIndex, m_idx);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    reqValidA = 0; reqValidB = 0; reqIndexA = '0; reqIndexB = '0;
    rspReadyA = 1; rspReadyB = 1;
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[3] = 32'hDEADBEEF; rf[1] = 32'd71; rf[2] = 32'd741;
    clear_n = 0;
    idle_inputs();

    // Reset then idle
    tick();
    clear_n = 1;
    #1;
    chk("rst_rspValidA", rspValidA, 0);
    chk("rst_rspValidB", rspValidB, 0);
    chk("rst_rspDataA", rspDataA, 0);
    chk("rst_rspDataB", rspDataB, 0);
    chk("rst_readIndex", readIndex, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reqReadyA", reqReadyA, 0);
    chk("rst_reqReadyB", reqReadyB, 0);

    // Single read of index 3
    reqValidA = 1; reqIndexA = 5'd3;
    #1 chk("single_reqReadyA", reqReadyA, 1);
    tick();
    reqValidA = 0;
    chk("single_readIndex", readIndex, 3);
    chk("single_busy_hi", busy, 1);
    tick();
    chk("single_rspValidA", rspValidA, 1);
    chk("single_rspDataA", rspDataA, 32'hDEADBEEF);
    chk("single_busy_lo", busy, 0);
    tick();
    chk("single_drained", rspValidA, 0);

    // Tie round-robin from a fresh reset
    clear_n = 0; tick(); clear_n = 1;
    reqValidA = 1; reqIndexA = 5'd1; reqValidB = 1; reqIndexB = 5'd2;
    #1;
    chk("tie_readyA", reqReadyA, 1);
    chk("tie_readyB", reqReadyB, 0);
    tick(); tick();
    chk("tie_rspDataA", rspDataA, 71);
    #1 chk("tie_readyB_next", reqReadyB, 1);
    tick(); tick();
    chk("tie_rspDataB", rspDataB, 741);
    #1 chk("tie_readyA_again", reqReadyA, 1);
    tick();
    reqValidA = 0; reqValidB = 0;
    tick(); tick(); tick();

    // Backpressure on A while B proceeds
    rspReadyA = 0; reqValidA = 1; reqIndexA = 5'd3;
    tick(); tick();
    held = rspDataA;
    chk("bp_held_data", held, 32'hDEADBEEF);
    reqValidB = 1; reqIndexB = 5'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rspValidA", rspValidA, 1);
      chk("bp_rspDataA", rspDataA, held);
      chk("bp_reqReadyA", reqReadyA, 0);
      tick();
    end
    chk("bp_rspDataB", rspDataB, 741);
    reqValidA = 0; reqValidB = 0; rspReadyA = 1;
    tick();
    chk("bp_rspValidA_clear", rspValidA, 0);
    tick(); tick(); tick();

    // Reset mid-read
    reqValidA = 1; reqIndexA = 5'd3;
    tick();
    reqValidA = 0; clear_n = 0;
    #1;
    chk("mid_readyA_rst", reqReadyA, 0);
    chk("mid_readyB_rst", reqReadyB, 0);
    tick();
    clear_n = 1;
    chk("mid_rspValidA", rspValidA, 0);
    chk("mid_rspDataA", rspDataA, 0);
    chk("mid_busy", busy, 0);
    reqValidA = 1; reqIndexA = 5'd4; reqValidB = 1; reqIndexB = 5'd5;
    #1 chk("mid_tie_A", reqReadyA, 1);
    reqValidA = 0; reqValidB = 0;
    tick(); tick();

    // Write-then-read coherence on index 0
    reqValidA = 1; reqIndexA = 5'd0;
    @(negedge clock);
    rf[0] = 32'd243;
    tick();
    reqValidA = 0;
    tick();
    chk("wtr_rspDataA", rspDataA, 243);
    tick(); tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clear_n   = ($urandom_range(0, 59) != 0);
      reqValidA = $urandom_range(0, 2) != 0;
      reqValidB = $urandom_range(0, 2) != 0;
      reqIndexA = IDX_W'($urandom);
      reqIndexB = IDX_W'($urandom);
      rspReadyA = $urandom_range(0, 9) < 6;
      rspReadyB = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
